clic_dispatch: RTL and testbench



---
 rtl/common_pkg.sv | 22 ++
 rtl/prio_stack.sv | 52 +++++
 rtl/clic_dispatch.sv | 117 +++++++++++
 tb/tb_clic_dispatch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared types and sizing for the CLIC dispatch slice: index/priority widths,
// default preemption depth and the dispatcher state encoding.
package common_pkg;

  localparam int NR_INDEX_BITS       = 4;
  localparam int NR_PRIO_BITS        = 3;
  localparam int STACK_DEPTH_DEFAULT = 4;

  typedef logic [NR_INDEX_BITS-1:0] Index;
  typedef logic [NR_PRIO_BITS-1:0]  Prio;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } dispatch_state_e;

  // Preemption needs strictly higher priority; equal priority never preempts.
  function automatic logic prio_preempts(input Prio cand, input Prio running);
    return (cand > running);
  endfunction

endpackage

// File: rtl/prio_stack.sv
// LIFO of saved running priorities; the top entry is visible combinationally
// so a pop returns its data in the same cycle.
module prio_stack #(
  parameter  int DEPTH = 4,
  parameter  int W     = 3,
  localparam int DW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [DW-1:0] depth
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [DW-1:0] r_depth;
  logic          w_full;
  logic          w_empty;

  assign w_full  = (r_depth == DW'(DEPTH));
  assign w_empty = (r_depth == '0);
  assign depth   = r_depth;

  // Top-of-stack read path.
  always_comb begin
    dout = '0;
    if (!w_empty) begin
      dout = r_mem[AW'(r_depth - 1'b1)];
    end else begin
      dout = '0;
    end
  end

  // Pointer and storage update; pop wins if both are requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_depth <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (pop && !w_empty) begin
      r_depth <= r_depth - 1'b1;
    end else if (push && !w_full) begin
      r_mem[AW'(r_depth)] <= din;
      r_depth             <= r_depth + 1'b1;
    end
  end

endmodule

// File: rtl/clic_dispatch.sv
// Interrupt dispatcher: qualifies the arbiter winner against the running
// priority, handshakes it to the core and tracks nesting on a priority stack.
module clic_dispatch
  import common_pkg::*;
#(
  parameter  int STACK_DEPTH = STACK_DEPTH_DEFAULT,
  localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          is_interrupt,
  input  Index          index,
  input  Prio           prio,
  output logic          irq_req,
  output Index          irq_index,
  input  logic          irq_ack,
  input  logic          irq_done,
  output logic          pend_clr,
  output Index          pend_clr_index,
  output Prio           cur_prio,
  output logic [DW-1:0] depth,
  output logic          stack_err
);

  dispatch_state_e r_state, w_state_nxt;
  Index            r_lat_idx, r_irq_index, r_pend_clr_index;
  Prio             r_lat_prio, r_cur_prio;
  logic            r_irq_req, r_pend_clr, r_stack_err;
  logic            w_qual, w_latch, w_push, w_pop, w_err_set;
  Prio             w_stack_dout;
  logic [DW-1:0]   w_depth;

  prio_stack #(.DEPTH(STACK_DEPTH), .W(NR_PRIO_BITS)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_cur_prio),
    .dout  (w_stack_dout),
    .depth (w_depth)
  );

  assign w_qual = is_interrupt && prio_preempts(prio, r_cur_prio)
                  && (w_depth < DW'(STACK_DEPTH));

  // Next state and stack commands; irq_done always outranks take and ack.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (irq_done) begin
          if (w_depth != '0) w_pop = 1'b1;
          else               w_err_set = 1'b1;
        end else if (w_qual) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (irq_done) begin
          w_state_nxt = ST_IDLE;
          if (w_depth != '0) w_pop = 1'b1;
          else               w_err_set = 1'b1;
        end else if (irq_ack) begin
          w_push      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, latched winner, running priority and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_lat_idx        <= '1;
      r_lat_prio       <= '0;
      r_cur_prio       <= '0;
      r_irq_req        <= 1'b0;
      r_irq_index      <= '1;
      r_pend_clr       <= 1'b0;
      r_pend_clr_index <= '1;
      r_stack_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_lat_idx  <= index;
        r_lat_prio <= prio;
      end
      r_irq_req        <= (w_state_nxt == ST_REQ);
      r_irq_index      <= (w_state_nxt != ST_REQ) ? '1 : (w_latch ? index : r_lat_idx);
      r_pend_clr       <= w_push;
      r_pend_clr_index <= w_push ? r_lat_idx : '1;
      if (w_pop)       r_cur_prio <= w_stack_dout;
      else if (w_push) r_cur_prio <= r_lat_prio;
      if (w_err_set)   r_stack_err <= 1'b1;
    end
  end

  assign irq_req        = r_irq_req;
  assign irq_index      = r_irq_index;
  assign pend_clr       = r_pend_clr;
  assign pend_clr_index = r_pend_clr_index;
  assign cur_prio       = r_cur_prio;
  assign depth          = w_depth;
  assign stack_err      = r_stack_err;

endmodule

// File: tb/tb_clic_dispatch.sv
// Directed bench for clic_dispatch: take, preempt/return, stability, stack
// full, done-wins, underflow and reset with hand-computed expectations.
module tb_clic_dispatch;

  logic       clk = 1'b0;
  logic       reset;
  logic       is_interrupt;
  logic [3:0] index;
  logic [2:0] prio;
  logic       irq_req;
  logic [3:0] irq_index;
  logic       irq_ack;
  logic       irq_done;
  logic       pend_clr;
  logic [3:0] pend_clr_index;
  logic [2:0] cur_prio;
  logic [2:0] depth;
  logic       stack_err;

  int n_tests = 0;
  int n_fail  = 0;

  clic_dispatch dut (
    .clk            (clk),
    .reset          (reset),
    .is_interrupt   (is_interrupt),
    .index          (index),
    .prio           (prio),
    .irq_req        (irq_req),
    .irq_index      (irq_index),
    .irq_ack        (irq_ack),
    .irq_done       (irq_done),
    .pend_clr       (pend_clr),
    .pend_clr_index (pend_clr_index),
    .cur_prio       (cur_prio),
    .depth          (depth),
    .stack_err      (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic take(input int idx, input int pr);
    is_interrupt = 1'b1; index = 4'(idx); prio = 3'(pr);
    tick();
    check_eq("take_req", int'(irq_req), 1);
    check_eq("take_idx", int'(irq_index), idx);
    is_interrupt = 1'b0; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check_eq("take_clr", int'(pend_clr), 1);
    check_eq("take_prio", int'(cur_prio), pr);
  endtask

  task automatic done_pulse();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},    int'(irq_req), 0);
    check_eq({tag, "_idx"},    int'(irq_index), 15);
    check_eq({tag, "_clr"},    int'(pend_clr), 0);
    check_eq({tag, "_clridx"}, int'(pend_clr_index), 15);
    check_eq({tag, "_prio"},   int'(cur_prio), 0);
    check_eq({tag, "_depth"},  int'(depth), 0);
    check_eq({tag, "_err"},    int'(stack_err), 0);
  endtask

  initial begin
    reset = 1'b1; is_interrupt = 1'b0; index = 4'd0; prio = 3'd0;
    irq_ack = 1'b0; irq_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_reset_outputs("rst");

    // Basic take: index 5, prio 3, ack two cycles after the request appears.
    is_interrupt = 1'b1; index = 4'd5; prio = 3'd3;
    tick();
    check_eq("basic_req", int'(irq_req), 1);
    check_eq("basic_idx", int'(irq_index), 5);
    is_interrupt = 1'b0;
    tick();
    check_eq("basic_hold", int'(irq_req), 1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check_eq("basic_clr", int'(pend_clr), 1);
    check_eq("basic_clridx", int'(pend_clr_index), 5);
    check_eq("basic_prio", int'(cur_prio), 3);
    check_eq("basic_depth", int'(depth), 1);
    check_eq("basic_reqoff", int'(irq_req), 0);
    tick();
    check_eq("basic_clr_once", int'(pend_clr), 0);

    // Lower and equal priority must not preempt.
    is_interrupt = 1'b1; index = 4'd2; prio = 3'd2;
    tick(); tick();
    check_eq("low_noreq", int'(irq_req), 0);
    prio = 3'd3;
    tick(); tick();
    check_eq("eq_noreq", int'(irq_req), 0);
    check_eq("eq_noidx", int'(irq_index), 15);
    take(7, 6);
    check_eq("pre_depth", int'(depth), 2);

    // Stability: arbiter moves to 9/prio 7 while index 5 is offered.
    is_interrupt = 1'b1; index = 4'd5; prio = 3'd7;
    tick();
    check_eq("stab_req", int'(irq_req), 1);
    index = 4'd9; prio = 3'd7;
    tick(); tick();
    check_eq("stab_idx", int'(irq_index), 5);
    is_interrupt = 1'b0; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check_eq("stab_clridx", int'(pend_clr_index), 5);
    check_eq("stab_prio", int'(cur_prio), 7);
    check_eq("stab_depth", int'(depth), 3);

    // Returns unwind 7 -> 6 -> 3 -> 0.
    done_pulse();
    check_eq("ret1_prio", int'(cur_prio), 6);
    tick();
    done_pulse();
    check_eq("ret2_prio", int'(cur_prio), 3);
    check_eq("ret2_depth", int'(depth), 1);
    tick();
    done_pulse();
    check_eq("ret3_prio", int'(cur_prio), 0);
    check_eq("ret3_depth", int'(depth), 0);
    check_eq("ret3_err", int'(stack_err), 0);
    tick();

    // Stack full: four nested takes, then prio 7 is held off until a return.
    take(1, 1); take(2, 2); take(3, 3); take(4, 4);
    check_eq("full_depth", int'(depth), 4);
    is_interrupt = 1'b1; index = 4'd12; prio = 3'd7;
    tick(); tick();
    check_eq("full_noreq", int'(irq_req), 0);
    done_pulse();
    check_eq("full_pop_depth", int'(depth), 3);
    check_eq("full_pop_prio", int'(cur_prio), 3);
    check_eq("full_pop_noreq", int'(irq_req), 0);
    tick();
    check_eq("full_req", int'(irq_req), 1);
    check_eq("full_idx", int'(irq_index), 12);

    // Done in REQ withdraws the request for a cycle, then requalifies.
    done_pulse();
    check_eq("dreq_req", int'(irq_req), 0);
    check_eq("dreq_depth", int'(depth), 2);
    check_eq("dreq_prio", int'(cur_prio), 2);
    tick();
    check_eq("dreq_reissue", int'(irq_req), 1);
    is_interrupt = 1'b0;
    done_pulse();
    check_eq("dreq2_prio", int'(cur_prio), 1);
    tick();
    done_pulse();
    check_eq("unwind_depth", int'(depth), 0);
    tick();

    // Done and ack together at depth 1: done wins.
    take(5, 3);
    is_interrupt = 1'b1; index = 4'd6; prio = 3'd5;
    tick();
    check_eq("dw_req", int'(irq_req), 1);
    is_interrupt = 1'b0; irq_ack = 1'b1; irq_done = 1'b1;
    tick();
    irq_ack = 1'b0; irq_done = 1'b0;
    check_eq("dw_noclr", int'(pend_clr), 0);
    check_eq("dw_depth", int'(depth), 0);
    check_eq("dw_prio", int'(cur_prio), 0);
    check_eq("dw_req_off", int'(irq_req), 0);
    tick();

    // Underflow sets a sticky error without disturbing state.
    done_pulse();
    check_eq("uf_err", int'(stack_err), 1);
    check_eq("uf_depth", int'(depth), 0);
    check_eq("uf_prio", int'(cur_prio), 0);
    tick();
    check_eq("uf_sticky", int'(stack_err), 1);

    // Reset mid-REQ with a concurrent ack: nothing pushed, all cleared.
    take(1, 2);
    is_interrupt = 1'b1; index = 4'd3; prio = 3'd4;
    tick();
    check_eq("rq_req", int'(irq_req), 1);
    reset = 1'b1; irq_ack = 1'b1;
    tick();
    check_reset_outputs("rq_rst");
    reset = 1'b0; irq_ack = 1'b0; is_interrupt = 1'b0;
    tick();
    check_eq("post_rst_depth", int'(depth), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
